// File: rtl/bench_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bench_uart_tx : FIFO-buffered 8N1 serial transmitter for wrapper output  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module bench_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int                 c_ADDR_W   = $clog2(FIFO_DEPTH);
  localparam int                 c_CNT_W    = 8;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ADDR_W:0]  r_wr_ptr;
  logic [c_ADDR_W:0]  r_rd_ptr;
  logic               r_overflow;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_next;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_next;
  logic               r_tx;
  logic               w_tx_next;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_cnt_done;
  logic [7:0]         w_head;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                      (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
  // No bypass: a pop in the same cycle never frees room for a push.
  assign w_push     = data_valid && !w_full;
  assign w_head     = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
  assign w_cnt_done = (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (data_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_cnt_next   = '0;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_cnt_done) begin
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_state_next = ST_DATA;
        end else begin
          w_cnt_next = r_cnt + c_CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (w_cnt_done) begin
          w_cnt_next   = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_state_next = ST_STOP;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt + c_CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (w_cnt_done) begin
          w_cnt_next = '0;
          // Back-to-back frames: a queued byte skips the idle state entirely.
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_head;
            w_state_next = ST_START;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    case (w_state_next)
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = w_shift_next[0];
      default:  w_tx_next = 1'b1;
    endcase
  end

  assign data_ready = !w_full;
  assign tx         = r_tx;
  assign busy       = (r_state != ST_IDLE) || !w_empty;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bench_uart_tx.sv
`default_nettype none
// Directed and randomized checks of bench_uart_tx against a frame-schedule model.
module tb_bench_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int MAXF  = 1024;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  bench_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: every accepted byte gets a push edge and a frame start edge.
  logic [7:0] m_byte  [MAXF];
  int         m_push  [MAXF];
  int         m_start [MAXF];
  int         m_n      = 0;
  logic       m_ovf    = 1'b0;
  logic       last_acc = 1'b0;

  function automatic int m_count(input int t);
    int c = 0;
    for (int i = 0; i < m_n; i++)
      if (m_push[i] <= t && m_start[i] > t) c++;
    return c;
  endfunction

  function automatic logic m_tx(input int t);
    for (int i = 0; i < m_n; i++) begin
      if (t >= m_start[i] && t < m_start[i] + FRAME) begin
        int k = (t - m_start[i]) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[i][k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic m_busy(input int t);
    for (int i = 0; i < m_n; i++)
      if (m_push[i] <= t && t < m_start[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("tx",         tx,         m_tx(cyc));
    chk("busy",       busy,       m_busy(cyc));
    chk("data_ready", data_ready, m_count(cyc) < DEPTH);
    chk("overflow",   overflow,   m_ovf);
  endtask

  // Called from negedge time; drives inputs, updates the model at the edge, checks at next negedge.
  task automatic cycle(input logic v, input logic [7:0] d);
    data_valid = v;
    data_in    = d;
    @(posedge clk);
    cyc++;
    last_acc = 1'b0;
    if (v) begin
      if (m_count(cyc - 1) < DEPTH) begin
        if (m_n < MAXF) begin
          m_byte[m_n]  = d;
          m_push[m_n]  = cyc;
          m_start[m_n] = cyc + 1;
          if (m_n > 0 && m_start[m_n-1] + FRAME > cyc + 1)
            m_start[m_n] = m_start[m_n-1] + FRAME;
          m_n++;
        end
        last_acc = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    data_valid = 1'b0;
    #1;
    chk("rst_tx",    tx,         1'b1);
    chk("rst_busy",  busy,       1'b0);
    chk("rst_ready", data_ready, 1'b1);
    chk("rst_ovf",   overflow,   1'b0);
    m_n   = 0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    int         s;
    reset_n    = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    @(negedge clk);
    do_reset();

    // Quiet line after reset
    idle(50);

    // Single frame
    cycle(1'b1, 8'hA5);
    idle(45);

    // Two back-to-back frames
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    idle(85);

    // Saturate the FIFO, then overflow
    v = 8'h01;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, v);
      if (last_acc) v = v + 8'h01;
      else break;
    end
    chk("burst_ready_low", data_ready, 1'b0);
    chk("burst_ovf_set",   overflow,   1'b1);
    idle(6 * FRAME);
    chk("ovf_sticky", overflow, 1'b1);

    // Reset in the middle of the data bits
    cycle(1'b1, 8'h3C);
    idle(10);
    do_reset();
    idle(3);
    cycle(1'b1, 8'h81);
    idle(45);

    // Byte queued during the last stop cycle: no idle gap
    cycle(1'b1, 8'h5A);
    s = m_start[m_n-1];
    while (cyc < s + FRAME - 2) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hC3);
    cycle(1'b0, 8'h00);
    chk("no_gap_start", tx, 1'b0);
    // Byte arriving on the final stop edge itself
    s = m_start[m_n-1];
    while (cyc < s + FRAME - 1) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h96);
    idle(FRAME + 5);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) == 0), 8'($urandom));
    end
    idle((DEPTH + 2) * FRAME);
    chk("final_idle_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bench_uart_tx.md
Name: bench_uart_tx

Overview:
- Downstream output stage for the benchmark wrapper: consumes the 8-bit selected-module result and transmits it serially on one pin.
- Lets the wrapper's multi-bit outputs be observed through a single IO.
- Byte format: 8N1 (start bit, 8 data bits LSB first, stop bit).
- A small FIFO absorbs bursts; a baud divider sets the bit time.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..255.
- FIFO_DEPTH, 4, byte buffer entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- data_in  input  8  byte to transmit; typically the wrapper's io_out.
- data_valid  input  1  byte offer strobe.
- data_ready  output  1  FIFO can accept a byte (= !full).
- tx  output  1  serial line; idles high.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- overflow  output  1  sticky flag: a byte was offered while the FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, overflow=0, data_ready=1.
  - FIFO emptied; FSM returns to IDLE; baud counter and bit index cleared.
- Reset mid-frame aborts the frame immediately: tx returns high with no stop bit.
- Push:
  - A byte is accepted on a rising edge where data_valid && data_ready.
  - data_ready is derived only from the registered full flag. There is no bypass: a push is refused when full, even if a pop happens in the same cycle.
- Overflow:
  - data_valid && !data_ready on an edge sets overflow; the byte is dropped.
  - overflow stays set until reset.
- FSM states: IDLE, START, DATA, STOP.
- tx is a registered output driven from the current state and shift register.
- IDLE:
  - tx=1.
  - If the FIFO is non-empty at an edge: pop the head into the shift register, clear the baud counter, enter START.
- START: tx=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the index.
  - After bit index 7 completes, enter STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At the end of STOP, if the FIFO is non-empty: pop and go straight to START, with no idle gap. Otherwise go to IDLE.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - A push at edge N into an empty FIFO with the FSM in IDLE gives a pop at edge N+1; tx goes low after edge N+1.
- Simultaneous push and pop in one cycle (not full): both occur; the FIFO count is unchanged.
- busy = (state != IDLE) || !empty.
  - busy rises the cycle after the first accepted push.
  - busy falls the cycle the FSM returns to IDLE with an empty FIFO.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full is when the MSBs differ and the remaining bits are equal.
- The FIFO is FIFO_DEPTH entries deep, and the active byte sits in the shift register. While a frame is in progress, FIFO_DEPTH further bytes are accepted before data_ready falls.

Test Plan:
- Reset, then idle 50 cycles -> tx=1, busy=0, data_ready=1, overflow=0 throughout.
- Push 0xA5 once (CLKS_PER_BIT=4) -> tx frame 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles (40 total); busy returns to 0 right after the stop bit.
- Push 0x00 and 0xFF on consecutive cycles -> two 40-cycle frames back to back, with the second start bit immediately after the first stop bit; data bits are all 0, then all 1.
- Hold data_valid high with data_in=0x01..0x06 (one new value per accepted cycle) while the first frame transmits -> data_ready falls after 5 accepts (1 popped + 4 buffered); the next offer sets overflow=1; the 5 accepted bytes appear on tx in order; overflow stays 1.
- Assert reset_n=0 mid-DATA of a 0x3C frame -> tx=1 and busy=0 immediately; after release, a push of 0x81 transmits cleanly with no remnant of 0x3C.
- Push exactly at the last STOP cycle with an otherwise empty FIFO -> the next START begins on the following cycle (no idle gap).
